mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit in EX for RV64M.
- Consumes the decode-side MulDiv enable and fun_3 select, plus the word-op flag (opcode[1]) and both operands.
- Stalls the pipeline while computing and presents one registered result for write-back.
- Multiply is radix-2 shift-add; divide is restoring; both are one bit per cycle.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
valid_i  input  1  EX holds an M-extension instruction (DivEn).
sel_i  input  3  fun_3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
word_i  input  1  W-variant (mulw/divw/divuw/remw/remuw).
src1_i  input  XLEN  rs1 operand.
src2_i  input  XLEN  rs2 operand.
flush_i  input  1  kill the in-flight operation (redirect or trap).
stall_o  output  1  hold PC, ID and EX this cycle.
done_o  output  1  result_o valid this cycle; single-cycle pulse.
result_o  output  XLEN  registered result.

Behaviour:
- Clocking: one clock domain; reset is asynchronous, active-low (clk, rst_n).
- Reset values: state=IDLE, done_o=0, result_o=0, counter=0, all datapath registers 0. stall_o=0 while rst_n low.
- States: IDLE, CALC, DONE.
- IDLE:
  - On valid_i & ~flush_i: latch operands and flags, then go to CALC.
  - Exception: a divide special case goes straight to DONE.
  - stall_o = valid_i & ~flush_i.
- Operand prep (accept cycle):
  - word_i: use src[31:0]. Sign-extend for signed ops, zero-extend for divuw/remuw.
  - Signed operands are replaced by their absolute values; sign flags are kept.
  - mulhsu: only src1 is treated as signed.
  - mul/mulhu and divu/remu: no sign processing.
- CALC:
  - Iterations: 64 for doubleword, 32 for word; the counter runs from N-1 down to 0.
  - stall_o=1.
  - On the last iteration, apply sign correction, register result_o, and go to DONE.
  - Multiply sign correction: negate the 128-bit product if signs differ.
  - Divide sign correction: quotient sign = s1^s2; remainder sign = s1.
- DONE:
  - done_o=1 and stall_o=0, so the pipeline advances on this edge.
  - Next state is always IDLE.
  - valid_i is ignored in DONE; no re-accept of the same instruction.
- Result select:
  - mul/mulw: product[63:0].
  - mulh/mulhsu/mulhu: product[127:64].
  - div*: quotient; rem*: remainder.
  - word_i: result = sext(r[31:0]).
  - word_i with sel 001..011 is treated as mulw.
- Divide by zero: quotient = all ones; remainder = dividend (word: sext(src1[31:0])). DONE is reached one cycle after accept.
- Signed overflow:
  - Condition: dividend = most negative and divisor = -1 (word: 0x80000000 / 0xFFFFFFFF).
  - Quotient = dividend (word: 0xFFFFFFFF80000000); remainder = 0.
  - DONE is reached one cycle after accept.
- Latency, accept to done_o:
  - Doubleword: 65 cycles.
  - Word: 33 cycles.
  - Special case: 1 cycle.
- Flush:
  - In any state, flush_i forces IDLE on the next edge and suppresses done_o; result_o is unchanged.
  - Flush has priority over accept.
  - Flush during DONE still lets done_o=1 show that cycle; write-back qualification is the pipeline's job.
- Reset mid-operation: immediate return to reset values; no result is produced.

Decomposition:
- defines.v gets:
  - MulDiv op encodings: MdMul..MdRemu, alongside the existing DivMul.
  - MDU state encodings.
  - Iteration-count constants: 64 and 32.
- Sub-module mdu_prep (combinational):
  - width extension, absolute value, sign flags;
  - special-case detection: div by zero, overflow.

Test Plan:
- mul, src1=0xFFFFFFFFFFFFFFFF (-1), src2=3 -> stall_o high for 65 cycles, then done_o=1 with result_o=0xFFFFFFFFFFFFFFFD.
- mulhu, src1=src2=0xFFFFFFFFFFFFFFFF -> result_o=0xFFFFFFFFFFFFFFFE; mulh with the same operands -> 0.
- div, src1=-7, src2=2 -> result_o=-3 (0xFFFFFFFFFFFFFFFD); rem with the same operands -> -1. Both at 65 cycles.
- divu, src2=0, src1=5 -> done_o at cycle 1 with result_o=0xFFFFFFFFFFFFFFFF; remu -> 5.
  - divw 0x80000000 / 0xFFFFFFFF -> result_o=0xFFFFFFFF80000000 at cycle 1.
- remw, src1=0x0000000100000007, src2=3 -> 33-cycle latency, result_o=1.
  - mulw 0x7FFFFFFF*2 -> result_o=0xFFFFFFFFFFFFFFFE.
- Abort cases, each returning to IDLE with done_o never asserted:
  - flush_i at CALC cycle 10;
  - rst_n low mid-CALC.
  - Then a new div 100/7 is accepted next cycle -> result_o=14.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared constants and types for the iterative RV64M multiply/divide unit.
//   MDU_XLEN    : datapath width (only 64 is supported)
//   ITER_DW/W   : iteration counts for doubleword and word operations
//   md_op_e     : fun_3 encodings of the M-extension operations
//   mdu_state_e : controller states
package mdu_iter_pkg;

   localparam int MDU_XLEN = 64;
   localparam int ITER_DW  = 64;
   localparam int ITER_W   = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX-stage request/response bundle between the pipeline and the MDU.
//   valid_i/sel_i/word_i/src1_i/src2_i : instruction request (fun_3, W flag, operands)
//   flush_i                            : kill the in-flight operation
//   stall_o/done_o/result_o            : pipeline hold, result strobe, registered result
//   master: pipeline side; slave: MDU side.
interface mdu_iter_if #(
   parameter int XLEN = mdu_iter_pkg::MDU_XLEN
) ();

   logic            valid_i;
   logic [2:0]      sel_i;
   logic            word_i;
   logic [XLEN-1:0] src1_i;
   logic [XLEN-1:0] src2_i;
   logic            flush_i;
   logic            stall_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output valid_i, sel_i, word_i, src1_i, src2_i, flush_i,
      input  stall_o, done_o, result_o
   );

   modport slave (
      input  valid_i, sel_i, word_i, src1_i, src2_i, flush_i,
      output stall_o, done_o, result_o
   );

endinterface

// File: rtl/mdu_iter_prep.sv
// mdu_iter_prep: combinational operand preparation for the MDU accept cycle.
//   sel_i, word_i, src1_i, src2_i : raw request
//   a_abs_o, b_abs_o              : width-extended magnitudes of the operands
//   s1_o, s2_o                    : operand sign flags (only for signed operands)
//   special_o, special_res_o      : divide-by-zero / signed-overflow detection and result
module mdu_iter_prep
   import mdu_iter_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic [2:0]      sel_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   output logic [XLEN-1:0] a_abs_o,
   output logic [XLEN-1:0] b_abs_o,
   output logic            s1_o,
   output logic            s2_o,
   output logic            special_o,
   output logic [XLEN-1:0] special_res_o
);

   logic            is_div, is_rem, signed1, signed2, div_zero, div_ovf;
   logic [XLEN-1:0] ext1, ext2, max_neg;

   always_comb begin
      is_div  = sel_i[2];
      is_rem  = sel_i[2] & sel_i[1];
      // Word multiplies only need the low 32 product bits, so they skip sign processing.
      signed1 = is_div ? ~sel_i[0] : (~word_i & ((sel_i == MD_MULH) | (sel_i == MD_MULHSU)));
      signed2 = is_div ? ~sel_i[0] : (~word_i & (sel_i == MD_MULH));

      ext1 = word_i ? {{(XLEN-32){src1_i[31] & signed1}}, src1_i[31:0]} : src1_i;
      ext2 = word_i ? {{(XLEN-32){src2_i[31] & signed2}}, src2_i[31:0]} : src2_i;

      s1_o    = signed1 & ext1[XLEN-1];
      s2_o    = signed2 & ext2[XLEN-1];
      a_abs_o = s1_o ? -ext1 : ext1;
      b_abs_o = s2_o ? -ext2 : ext2;

      max_neg  = word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = is_div & (ext2 == '0);
      div_ovf  = is_div & ~sel_i[0] & (ext1 == max_neg) & (&ext2);
      special_o = div_zero | div_ovf;

      if (div_zero)
         special_res_o = is_rem ? ext1 : '1;
      else
         special_res_o = is_rem ? '0 : ext1;
   end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit for the EX stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mdu_iter_if.slave (request, flush, stall, done strobe, registered result)
// Multiply is radix-2 shift-add and divide is restoring, one bit per cycle.
// acc_q holds {hi, lo}: product accumulator / multiplier for multiply,
// partial remainder / dividend-quotient for divide. opnd_q holds multiplicand or divisor.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic       clk,
   input  logic       rst_n,
   mdu_iter_if.slave  bus
);

   localparam int CW = $clog2(XLEN);

   mdu_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              is_div_q, is_div_d, is_rem_q, is_rem_d, is_hi_q, is_hi_d;
   logic              word_q, word_d, s1_q, s1_d, s2_q, s2_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [XLEN-1:0]   a_abs, b_abs, special_res;
   logic              s1, s2, special;

   logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
   logic [2*XLEN-1:0] acc_step, prod;
   logic [XLEN-1:0]   quo, rmd, res_raw, res_fin, special_fin;

   mdu_iter_prep #(.XLEN(XLEN)) u_prep (
      .sel_i         (bus.sel_i),
      .word_i        (bus.word_i),
      .src1_i        (bus.src1_i),
      .src2_i        (bus.src2_i),
      .a_abs_o       (a_abs),
      .b_abs_o       (b_abs),
      .s1_o          (s1),
      .s2_o          (s2),
      .special_o     (special),
      .special_res_o (special_res)
   );

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      is_rem_d = is_rem_q;
      is_hi_d  = is_hi_q;
      word_d   = word_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      done_d   = 1'b0;
      result_d = result_q;

      // One iteration step for whichever operation is in flight.
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      rem_sub = rem_sh - {1'b0, opnd_q};
      if (is_div_q) begin
         if (rem_sh >= {1'b0, opnd_q})
            acc_step = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         else
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end

      // After 32 shift-add steps the word product sits 32 bits up in the accumulator.
      prod = word_q ? (acc_step >> 32) : acc_step;
      if (s1_q ^ s2_q)
         prod = -prod;
      quo = acc_step[XLEN-1:0];
      rmd = acc_step[2*XLEN-1:XLEN];
      if (s1_q ^ s2_q)
         quo = -quo;
      if (s1_q)
         rmd = -rmd;

      if (is_div_q)
         res_raw = is_rem_q ? rmd : quo;
      else
         res_raw = is_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      res_fin     = word_q ? {{(XLEN-32){res_raw[31]}}, res_raw[31:0]} : res_raw;
      special_fin = bus.word_i ? {{(XLEN-32){special_res[31]}}, special_res[31:0]} : special_res;

      if (bus.flush_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.valid_i) begin
                  is_div_d = bus.sel_i[2];
                  is_rem_d = bus.sel_i[2] & bus.sel_i[1];
                  is_hi_d  = ~bus.word_i & ~bus.sel_i[2] & (bus.sel_i[1:0] != 2'b00);
                  word_d   = bus.word_i;
                  s1_d     = s1;
                  s2_d     = s2;
                  if (special) begin
                     result_d = special_fin;
                     done_d   = 1'b1;
                     state_d  = ST_DONE;
                  end else begin
                     cnt_d   = bus.word_i ? CW'(ITER_W - 1) : CW'(ITER_DW - 1);
                     state_d = ST_CALC;
                     if (bus.sel_i[2]) begin
                        opnd_d = b_abs;
                        // Word dividends start at the top of lo so 32 left shifts consume them.
                        acc_d  = bus.word_i ? {{XLEN{1'b0}}, a_abs[31:0], {(XLEN-32){1'b0}}}
                                            : {{XLEN{1'b0}}, a_abs};
                     end else begin
                        opnd_d = a_abs;
                        acc_d  = {{XLEN{1'b0}}, b_abs};
                     end
                  end
               end
            end
            ST_CALC: begin
               acc_d = acc_step;
               if (cnt_q == '0) begin
                  result_d = res_fin;
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         is_rem_q <= 1'b0;
         is_hi_q  <= 1'b0;
         word_q   <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         is_rem_q <= is_rem_d;
         is_hi_q  <= is_hi_d;
         word_q   <= word_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Stall is combinational so the accept cycle already holds the pipeline.
   assign bus.stall_o  = rst_n & (((state_q == ST_IDLE) & bus.valid_i & ~bus.flush_i) |
                                  (state_q == ST_CALC));
   assign bus.done_o   = done_q;
   assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter.
// Drives inputs on the falling edge and samples outputs there too.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mdu_iter_if #(.XLEN(64)) bus ();

   mdu_iter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Issue one instruction and follow it to done_o, checking latency, stall length and result.
   task automatic run_op(input string tag, input logic [2:0] sel, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
      int lat;
      int stalls;
      bit seen;
      @(negedge clk);
      bus.sel_i   = sel;
      bus.word_i  = word;
      bus.src1_i  = a;
      bus.src2_i  = b;
      bus.valid_i = 1'b1;
      #1;
      stalls = bus.stall_o ? 1 : 0;
      lat    = 0;
      seen   = 1'b0;
      while (!seen && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.valid_i = 1'b0;
         if (bus.done_o)
            seen = 1'b1;
         else if (bus.stall_o)
            stalls++;
      end
      check({tag, " done seen"}, 64'(seen), 64'd1);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
      check({tag, " result"}, bus.result_o, exp_res);
      check({tag, " stall in done"}, 64'(bus.stall_o), 64'd0);
      @(negedge clk);
      check({tag, " done pulse"}, 64'(bus.done_o), 64'd0);
   endtask

   // Watch a window of cycles in which done_o must stay low.
   task automatic expect_no_done(input string tag, input int cycles);
      int hits;
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done_o)
            hits++;
      end
      check({tag, " no done"}, 64'(hits), 64'd0);
   endtask

   task automatic start_op(input logic [2:0] sel, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      bus.sel_i   = sel;
      bus.word_i  = 1'b0;
      bus.src1_i  = a;
      bus.src2_i  = b;
      bus.valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.valid_i = 1'b1;
      bus.flush_i = 1'b0;
      bus.sel_i   = MD_MUL;
      bus.word_i  = 1'b0;
      bus.src1_i  = 64'd1;
      bus.src2_i  = 64'd1;
      #2;
      check("reset stall", 64'(bus.stall_o), 64'd0);
      check("reset done", 64'(bus.done_o), 64'd0);
      check("reset result", bus.result_o, 64'd0);
      bus.valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul -1*3",     MD_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,  64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("mulhu max",    MD_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_op("mulh -1*-1",   MD_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
      run_op("mulhsu -1*2",  MD_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,  64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("div -7/2",     MD_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("rem -7%2",     MD_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("divu big/16",  MD_DIVU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
      run_op("divu 5/0",     MD_DIVU,   1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("remu 5%0",     MD_REMU,   1'b0, 64'd5, 64'd0, 64'd5, 1);
      run_op("div ovf",      MD_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      run_op("rem ovf",      MD_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      run_op("divw ovf",     MD_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      run_op("remw x%0",     MD_REM,    1'b1, 64'h1234_5678_8765_4321, 64'd0, 64'hFFFF_FFFF_8765_4321, 1);
      run_op("remw 7%3",     MD_REM,    1'b1, 64'h0000_0001_0000_0007, 64'd3,  64'd1, 33);
      run_op("remuw",        MD_REMU,   1'b1, 64'h0000_0000_FFFF_FFFF, 64'd10, 64'd5, 33);
      run_op("mulw",         MD_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,  64'hFFFF_FFFF_FFFF_FFFE, 33);

      // Flush at the tenth CALC cycle: back to IDLE, no done, result untouched.
      start_op(MD_DIV, 64'd1000, 64'd3);
      repeat (9) @(negedge clk);
      bus.flush_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush_i = 1'b0;
      check("flush stall", 64'(bus.stall_o), 64'd0);
      expect_no_done("flush", 80);
      check("flush result kept", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush wins over a simultaneous request.
      @(negedge clk);
      bus.sel_i   = MD_DIV;
      bus.word_i  = 1'b0;
      bus.src1_i  = 64'd9;
      bus.src2_i  = 64'd3;
      bus.valid_i = 1'b1;
      bus.flush_i = 1'b1;
      #1;
      check("flush prio stall", 64'(bus.stall_o), 64'd0);
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      expect_no_done("flush prio", 70);

      // Reset in the middle of CALC.
      start_op(MD_MUL, 64'd12345, 64'd678);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset stall", 64'(bus.stall_o), 64'd0);
      check("midreset result", bus.result_o, 64'd0);
      check("midreset done", 64'(bus.done_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_no_done("midreset", 80);

      run_op("div 100/7", MD_DIV, 1'b0, 64'd100, 64'd7, 64'd14, 65);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
